// File: rtl/sync_fifo.sv
// Purpose : single-clock FIFO, 2**ADDR_WIDTH words, binary read/write pointers.
// Latency : 1 cycle i_rd -> o_data/o_valid; status flags update on the access edge.
// Backpr. : writes rejected while full (o_overflow pulse), reads rejected while empty
//           (o_underflow pulse); a rejected access changes no pointer or storage.
//
// Ports   : i_clk, i_rst_n (async, active low)
//           i_wr/i_data      write request and word
//           i_rd             read request
//           o_data/o_valid   registered read word, valid the cycle after an accepted read
//           o_full/o_empty/o_level   pointer-derived occupancy
//           o_overflow/o_underflow   one-cycle pulses after a rejected access
//           o_almost_full/o_almost_empty  threshold flags, built only with `FIFO_ALMOST_EN
//                                         (tied to 0 otherwise)
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_rd,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_level,
   output logic                  o_overflow,
   output logic                  o_underflow,
   output logic                  o_almost_full,
   output logic                  o_almost_empty
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   logic                  full, empty, wr_acc, rd_acc;
   logic [ADDR_WIDTH:0]   level;

   always_comb begin
      level  = wr_ptr_q - rd_ptr_q;
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
               (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
      // Flags are judged on current state only: a read never bypasses a write
      // into an empty FIFO, and a write never uses the slot a read frees when full.
      wr_acc = i_wr && !full;
      rd_acc = i_rd && !empty;

      wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
      data_d   = rd_acc ? mem[rd_ptr_q[ADDR_WIDTH-1:0]] : data_q;
      valid_d  = rd_acc;
      ovf_d    = i_wr && full;
      udf_d    = i_rd && empty;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not reset; the pointers alone define contents.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_data;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_full      = full;
   assign o_empty     = empty;
   assign o_level     = level;
   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;

`ifdef FIFO_ALMOST_EN
   localparam logic [ADDR_WIDTH:0] AF_LVL = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_LVL = AE_LEVEL[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0] level_d;
   logic                af_q, af_d;
   logic                ae_q, ae_d;

   // Registered from next-state pointers so they move on the same edge as o_level.
   always_comb begin
      level_d = wr_ptr_d - rd_ptr_d;
      af_d    = (level_d >= AF_LVL);
      ae_d    = (level_d <= AE_LVL);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= af_d;
         ae_q <= ae_d;
      end
   end

   assign o_almost_full  = af_q;
   assign o_almost_empty = ae_q;
`else
   // Thresholds only matter when the almost flags are built.
   logic unused_thr;
   assign unused_thr     = (AF_LEVEL > AE_LEVEL);
   assign o_almost_full  = 1'b0;
   assign o_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=4): reference queue of stored
// words plus a scoreboard of words expected on o_data.
module tb_sync_fifo;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_wr;
   logic [7:0] i_data;
   logic       i_rd;
   logic [7:0] o_data;
   logic       o_valid, o_full, o_empty;
   logic [4:0] o_level;
   logic       o_overflow, o_underflow, o_almost_full, o_almost_empty;

   sync_fifo dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
      .o_data(o_data), .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
      .o_level(o_level), .o_overflow(o_overflow), .o_underflow(o_underflow),
      .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty)
   );

   always #5 i_clk = ~i_clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_q[$];   // words currently stored
   logic [7:0] exp_q[$];     // words expected on o_data
   logic       exp_valid, exp_ovf, exp_udf;
   logic [7:0] last_rd = 8'h00;

   function automatic logic exp_af(int lvl);
`ifdef FIFO_ALMOST_EN
      return lvl >= 12;
`else
      return 1'b0 & (lvl > 0);
`endif
   endfunction

   function automatic logic exp_ae(int lvl);
`ifdef FIFO_ALMOST_EN
      return lvl <= 4;
`else
      return 1'b0 & (lvl > 0);
`endif
   endfunction

   // One clock of stimulus; updates the reference model before the edge and
   // returns #1 after it so outputs can be sampled.
   task automatic drive(input logic wr, input logic [7:0] d, input logic rd);
      logic wa, ra;
      wa = wr && (model_q.size() != 16);
      ra = rd && (model_q.size() != 0);
      i_wr = wr; i_data = d; i_rd = rd;
      if (ra) exp_q.push_back(model_q.pop_front());
      if (wa) model_q.push_back(d);
      exp_valid = ra;
      exp_ovf   = wr && !wa;
      exp_udf   = rd && !ra;
      @(posedge i_clk);
      #1;
      i_wr = 1'b0; i_rd = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_data = 8'h00;
      #12;
      checks++;
      if ({o_data, o_valid, o_empty, o_full, o_level, o_overflow, o_underflow}
          !== {8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got data=%h v=%b e=%b f=%b lvl=%0d ov=%b un=%b",
                  o_data, o_valid, o_empty, o_full, o_level, o_overflow, o_underflow);
      end
      checks++;
      if ({o_almost_full, o_almost_empty} !== {exp_af(1), exp_ae(0) | (exp_ae(1) & 1'b1)}) begin
         errors++;
         $display("FAIL reset_almost: got af=%b ae=%b", o_almost_full, o_almost_empty);
      end
      #8 i_rst_n = 1'b1;
   endtask

   task automatic test_fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, base + 8'(i), 1'b0);
         checks++;
         if (o_level !== 5'(model_q.size()) || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_level: got %0d ov=%b expected %0d", o_level, o_overflow, model_q.size());
         end
         checks++;
         if (o_almost_full !== exp_af(model_q.size()) || o_almost_empty !== exp_ae(model_q.size())) begin
            errors++;
            $display("FAIL fill_almost: lvl %0d got af=%b ae=%b expected af=%b ae=%b", model_q.size(),
                     o_almost_full, o_almost_empty, exp_af(model_q.size()), exp_ae(model_q.size()));
         end
      end
      checks++;
      if (o_full !== 1'b1 || o_empty !== 1'b0 || o_level !== 5'd16) begin
         errors++;
         $display("FAIL fill_full: got f=%b e=%b lvl=%0d expected f=1 e=0 lvl=16", o_full, o_empty, o_level);
      end
   endtask

   task automatic test_drain(input int n);
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         checks++;
         if (o_valid !== exp_valid) begin
            errors++;
            $display("FAIL drain_valid: got %b expected %b", o_valid, exp_valid);
         end
         if (o_valid === 1'b1 && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            last_rd = exp;
            checks++;
            if (o_data !== exp) begin
               errors++;
               $display("FAIL drain_data: got %h expected %h", o_data, exp);
            end
         end
      end
      checks++;
      if (o_level !== 5'(model_q.size()) || o_empty !== (model_q.size() == 0)) begin
         errors++;
         $display("FAIL drain_level: got lvl=%0d e=%b expected lvl=%0d", o_level, o_empty, model_q.size());
      end
   endtask

   task automatic test_overflow();
      test_fill(8'h00);
      drive(1'b1, 8'hAA, 1'b0);
      checks++;
      if (o_overflow !== 1'b1 || o_level !== 5'd16 || o_full !== 1'b1) begin
         errors++;
         $display("FAIL overflow_pulse: got ov=%b lvl=%0d f=%b expected 1/16/1", o_overflow, o_level, o_full);
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: got %b expected 0", o_overflow);
      end
      test_drain(16);   // contents must still be 0x00..0x0F
   endtask

   task automatic test_underflow();
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (o_underflow !== 1'b1 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL underflow_pulse: got un=%b v=%b expected un=1 v=0", o_underflow, o_valid);
      end
      checks++;
      if (o_data !== last_rd) begin
         errors++;
         $display("FAIL underflow_hold: got data=%h expected %h", o_data, last_rd);
      end
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if (o_underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_clear: got %b expected 0", o_underflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      drive(1'b1, 8'h55, 1'b1);
      checks++;
      if (o_level !== 5'd1 || o_valid !== 1'b0 || o_underflow !== exp_udf) begin
         errors++;
         $display("FAIL empty_rw: got lvl=%0d v=%b un=%b expected lvl=1 v=0 un=%b",
                  o_level, o_valid, o_underflow, exp_udf);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'h80 + 8'(i), 1'b1);
         checks++;
         if (o_level !== 5'd5 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_level: cycle %0d got lvl=%0d v=%b expected lvl=5 v=1", i, o_level, o_valid);
         end
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            last_rd = exp;
            checks++;
            if (o_data !== exp) begin
               errors++;
               $display("FAIL b2b_data: cycle %0d got %h expected %h", i, o_data, exp);
            end
         end
      end
      test_drain(5);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
      #3 i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_empty !== 1'b1 || o_level !== 5'd0 || o_full !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got e=%b lvl=%0d f=%b v=%b expected e=1 lvl=0 f=0 v=0",
                  o_empty, o_level, o_full, o_valid);
      end
      model_q.delete();
      exp_q.delete();
      #2 i_rst_n = 1'b1;
      drive(1'b1, 8'h77, 1'b0);
      test_drain(1);
   endtask

   initial begin
      test_reset();
      test_fill(8'h00);
      test_drain(16);
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
